// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV64 pipeline: E-stage forwarding, load-use bubbles,
// branch flushes and multi-cycle execute sequencing. HAZARD_PERF_EN adds stall/flush counters.
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal issue; branch flush, load-use bubble or mc issue
// MC_WAIT | multi-cycle op in E; front end held until done or timeout
module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RS1_E,
    input  logic [4:0]       RS2_E,
    input  logic [4:0]       RD_E,
    input  logic [4:0]       RD_M,
    input  logic [4:0]       RD_W,
    input  logic             ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             McStartE,
    input  logic             McDoneE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             McErr,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int TMR_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    // Down-counter loaded on entry; reaching zero marks the last allowed wait cycle.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MC_TIMEOUT - 1);

    typedef enum logic {RUN, MC_WAIT} state_t;

    state_t           state;
    logic [TMR_W-1:0] tmr;
    logic             mc_err;
    logic             lw_stall;
    logic             tmr_done;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        lw_stall  = ResultSrcE && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
        tmr_done  = (tmr == '0);
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        if (rst) begin
            ForwardAE = fwd_sel(RS1_E, RegWriteM, RD_M, RegWriteW, RD_W);
            ForwardBE = fwd_sel(RS2_E, RegWriteM, RD_M, RegWriteW, RD_W);
            case (state)
                RUN: begin
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (McStartE) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end else if (lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MC_WAIT: begin
                    // Done or timeout is the release cycle: result moves on to M.
                    if (!(McDoneE || tmr_done)) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= RUN;
            tmr    <= '0;
            mc_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (!PCSrcE && McStartE) begin
                        state <= MC_WAIT;
                        tmr   <= TMR_LOAD;
                    end
                end
                MC_WAIT: begin
                    if (McDoneE || tmr_done) begin
                        state <= RUN;
                        if (!McDoneE)
                            mc_err <= 1'b1;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign McErr = mc_err & rst;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating: a pinned counter is more useful than one that silently wrapped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (FlushD && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign StallCount = stall_cnt;
    assign FlushCount = flush_cnt;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MC_TIMEOUT=8; expected output vectors go through a queue.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             clk;
    logic             rst;
    logic [4:0]       RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
    logic             ResultSrcE, RegWriteM, RegWriteW, PCSrcE, McStartE, McDoneE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM, McErr;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];
    string       tag_q[$];
    int unsigned exp_stall = 0;
    int unsigned exp_flush = 0;
    logic        err_exp = 1'b0;

    hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .McStartE(McStartE), .McDoneE(McDoneE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .McErr(McErr), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {FA, FB, StallF, StallD, StallE, FlushD, FlushE, FlushM, McErr}
    function automatic logic [10:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic fm,
                                       input logic err);
        return {fa, fb, sf, sd, se, fd, fe, fm, err};
    endfunction

    task automatic clear_inputs();
        RS1_D = 0; RS2_D = 0; RS1_E = 0; RS2_E = 0;
        RD_E = 0; RD_M = 0; RD_W = 0;
        ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        PCSrcE = 0; McStartE = 0; McDoneE = 0;
    endtask

    // Push the expectation for the inputs just driven, compare mid-cycle, then advance.
    task automatic cyc(input string tag, input logic [10:0] e);
        logic [10:0] obs, exp_v;
        string       t;
        logic [CNT_W-1:0] exp_sc, exp_fc;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        obs   = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McErr};
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", t, obs, exp_v);
        end
`ifdef HAZARD_PERF_EN
        exp_sc = CNT_W'(exp_stall);
        exp_fc = CNT_W'(exp_flush);
`else
        exp_sc = '0;
        exp_fc = '0;
`endif
        if (rst) begin
            checks++;
            assert (StallCount === exp_sc) else begin
                errors++;
                $error("FAIL %s_stallcnt: observed %0d expected %0d", t, StallCount, exp_sc);
            end
            checks++;
            assert (FlushCount === exp_fc) else begin
                errors++;
                $error("FAIL %s_flushcnt: observed %0d expected %0d", t, FlushCount, exp_fc);
            end
            if (exp_v[6]) exp_stall++;
            if (exp_v[3]) exp_flush++;
        end else begin
            exp_stall = 0;
            exp_flush = 0;
        end
        @(posedge clk);
        #1;
    endtask

    logic [10:0] mc, lw, br;

    initial begin
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        // Reset held: every hazard source active, outputs must stay low.
        RegWriteM = 1; RD_M = 5; RS1_E = 5; PCSrcE = 1; ResultSrcE = 1;
        RD_E = 7; RS1_D = 7; McStartE = 1;
        cyc("rst_force", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        clear_inputs();
        cyc("idle", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; RS1_E = 5; RS2_E = 0;
        cyc("fwd_m_prio", ev(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        RegWriteM = 0;
        cyc("fwd_w", ev(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        RegWriteM = 1; RS1_E = 3; RS2_E = 5;
        cyc("fwd_b_m", ev(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        RD_M = 0; RD_W = 0; RS1_E = 0; RS2_E = 0;
        cyc("fwd_x0", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        lw = ev(0, 0, 1, 1, 0, 0, 1, 0, 0);
        br = ev(0, 0, 0, 0, 0, 1, 1, 0, 0);
        mc = ev(0, 0, 1, 1, 1, 0, 0, 1, 0);

        clear_inputs();
        ResultSrcE = 1; RD_E = 7; RS2_D = 7;
        cyc("lw_stall", lw);
        ResultSrcE = 0; RD_E = 0;
        cyc("lw_bubble", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        ResultSrcE = 1; RD_E = 0; RS1_D = 0; RS2_D = 0;
        cyc("lw_x0", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        RD_E = 7; RS1_D = 7; PCSrcE = 1;
        cyc("lw_branch", br);

        clear_inputs();
        McStartE = 1; PCSrcE = 1;
        cyc("branch_over_mc", br);
        clear_inputs();
        cyc("no_mc_wait", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        McStartE = 1;
        cyc("mc_issue", mc);
        McStartE = 0; PCSrcE = 1; ResultSrcE = 1; RD_E = 7; RS1_D = 7;
        for (int i = 0; i < 4; i++) cyc("mc_wait", mc);
        clear_inputs();
        McDoneE = 1;
        cyc("mc_done", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        ResultSrcE = 1; RD_E = 7; RS1_D = 7;
        cyc("run_after_done", lw);
        clear_inputs();
        cyc("idle2", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));

        McStartE = 1;
        cyc("to_issue", mc);
        McStartE = 0;
        for (int i = 0; i < 7; i++) cyc("to_wait", mc);
        cyc("to_release", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        err_exp = 1'b1;
        cyc("mcerr_set", ev(0, 0, 0, 0, 0, 0, 0, 0, err_exp));
        RegWriteW = 1; RD_W = 9; RS2_E = 9;
        cyc("mcerr_fwd", ev(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, err_exp));
        clear_inputs();
        McStartE = 1;
        cyc("sticky_issue", ev(0, 0, 1, 1, 1, 0, 0, 1, err_exp));
        McStartE = 0; McDoneE = 1;
        cyc("sticky_done", ev(0, 0, 0, 0, 0, 0, 0, 0, err_exp));
        McDoneE = 0;
        cyc("sticky_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, err_exp));

        McStartE = 1;
        cyc("rm_issue", ev(0, 0, 1, 1, 1, 0, 0, 1, err_exp));
        McStartE = 0;
        cyc("rm_wait1", ev(0, 0, 1, 1, 1, 0, 0, 1, err_exp));
        cyc("rm_wait2", ev(0, 0, 1, 1, 1, 0, 0, 1, err_exp));
        rst = 1'b0;
        cyc("rm_reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        err_exp = 1'b0;
        rst = 1'b1;
        ResultSrcE = 1; RD_E = 7; RS2_D = 7; McDoneE = 1;
        cyc("rm_run", ev(0, 0, 1, 1, 0, 0, 1, 0, err_exp));
        clear_inputs();
        cyc("rm_idle", ev(0, 0, 0, 0, 0, 0, 0, 0, err_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
